// File: rtl/ascon_job_sequencer.sv
// Ascon job sequencer: feeds AD then text blocks from a host stream into a cipher core.
// Define ASCON_SEQ_TIMEOUT_EN to add a watchdog on the core handshake and finish wait.
module ascon_job_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_start,
  input  logic         job_encrypt,
  input  logic [3:0]   job_ad_blocks,
  input  logic [3:0]   job_pt_blocks,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         core_start,
  output logic         core_encrypt,
  output logic         core_sel_data,
  output logic         core_last_block,
  output logic [127:0] core_din,
  output logic         core_din_req,
  input  logic         core_din_ack,
  input  logic [127:0] core_dout,
  input  logic         core_do_req,
  output logic         core_do_ack,
  input  logic         core_finished
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStart   = 3'd1;
  localparam logic [2:0] StAdFetch = 3'd2;
  localparam logic [2:0] StAdReq   = 3'd3;
  localparam logic [2:0] StPtFetch = 3'd4;
  localparam logic [2:0] StPtReq   = 3'd5;
  localparam logic [2:0] StWaitFin = 3'd6;
  localparam logic [2:0] StDone    = 3'd7;

  logic [2:0]   state_q, state_d;
  logic         enc_q;
  logic [3:0]   ad_cnt_q, pt_cnt_q;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] din_q;
  logic [3:0]   out_cnt_q;
  logic         err_q, err_d;
  logic         accept, ad_last, pt_last;

  assign accept  = (state_q == StIdle) && job_start && (job_pt_blocks != 4'd0);
  assign ad_last = (idx_q == (ad_cnt_q - 4'd1));
  assign pt_last = (idx_q == (pt_cnt_q - 4'd1));

`ifdef ASCON_SEQ_TIMEOUT_EN
  logic [9:0] wd_q, wd_d;
  logic       wd_run;

  assign wd_run = (state_q == StAdReq) || (state_q == StPtReq) || (state_q == StWaitFin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (job_start) begin
          if (job_pt_blocks == 4'd0) err_d = 1'b1;
          else state_d = StStart;
        end
      end
      StStart: begin
        idx_d   = '0;
        state_d = (ad_cnt_q != 4'd0) ? StAdFetch : StPtFetch;
      end
      StAdFetch: if (blk_valid) state_d = StAdReq;
      StAdReq: begin
        if (core_din_ack) begin
          if (ad_last) begin
            idx_d   = '0;
            state_d = StPtFetch;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StAdFetch;
          end
        end
      end
      StPtFetch: if (blk_valid) state_d = StPtReq;
      StPtReq: begin
        if (core_din_ack) begin
          if (pt_last) begin
            state_d = StWaitFin;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StPtFetch;
          end
        end
      end
      StWaitFin: if (core_finished) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
`ifdef ASCON_SEQ_TIMEOUT_EN
    // Count only while parked in a waiting state; any transition restarts it.
    wd_d = '0;
    if (wd_run && (state_d == state_q)) wd_d = wd_q + 10'd1;
    if (wd_d == 10'h3ff) begin
      state_d = StIdle;
      err_d   = 1'b1;
      wd_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      enc_q     <= 1'b0;
      ad_cnt_q  <= '0;
      pt_cnt_q  <= '0;
      idx_q     <= '0;
      din_q     <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (accept) begin
        enc_q    <= job_encrypt;
        ad_cnt_q <= job_ad_blocks;
        pt_cnt_q <= job_pt_blocks;
      end
      if (blk_ready && blk_valid) din_q <= blk_data;
      if (accept) out_cnt_q <= '0;
      else if (core_do_ack) out_cnt_q <= out_cnt_q + 4'd1;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign err             = err_q;
  assign blk_ready       = (state_q == StAdFetch) || (state_q == StPtFetch);
  assign core_start      = (state_q == StStart);
  assign core_din_req    = (state_q == StAdReq) || (state_q == StPtReq);
  assign core_sel_data   = (state_q == StPtFetch) || (state_q == StPtReq);
  assign core_last_block = ((state_q == StAdReq) && ad_last) || ((state_q == StPtReq) && pt_last);
  assign core_encrypt    = enc_q;
  assign core_din        = din_q;

  // Output stream is a straight pass-through of the core's output handshake.
  assign out_valid   = core_do_req;
  assign out_data    = core_dout;
  assign core_do_ack = core_do_req && out_ready;
  assign out_last    = out_valid && (out_cnt_q == (pt_cnt_q - 4'd1));

endmodule
